// File: rtl/usb_serial_recv_buffer.sv
// usb_serial_recv_buffer
//   Host-to-device receive buffer for the USB CDC serial path. Bytes arrive as
//   one-cycle pulses from the EP01 OUT endpoint with no backpressure. They are
//   stored in a 2^ASIZE-byte RAM FIFO and presented as a first-word-fall-through
//   valid/ready stream through a 2-entry skid stage. Because the endpoint cannot
//   be throttled, bytes arriving while the RAM is full are dropped and counted.
//
// Parameters:
//   ASIZE        log2 of RAM depth (4..14)
//   AFULL_LEVEL  level at or above which almost_full is set
//
// Ports:
//   clk           system clock (USB core domain)
//   rst           synchronous active-high reset, clears everything
//   usb_rstn      0 = synchronous flush of buffered data (overflow stats kept)
//   wr_data       received byte
//   wr_valid      one-cycle pulse per received byte
//   rd_data       byte at head of stream
//   rd_valid      rd_data valid
//   rd_ready      consumer accepts (transfer on rd_valid & rd_ready)
//   level         bytes held (RAM + in-flight read + skid stage), registered
//   almost_full   level >= AFULL_LEVEL, registered
//   overflow      sticky: at least one byte dropped
//   overflow_cnt  dropped-byte count, saturating
//   clr_overflow  clears overflow and overflow_cnt (a same-cycle drop wins)
//   rd_eol        rd_valid with rd_data == 8'h0A      (RECV_LINE_DETECT_EN only)
//   line_pending  at least one 8'h0A byte is held     (RECV_LINE_DETECT_EN only)
//
// Optional feature macro: RECV_LINE_DETECT_EN enables the line-end detection
// outputs rd_eol and line_pending.

module usb_serial_recv_buffer #(
   parameter int unsigned ASIZE       = 10,
   parameter int unsigned AFULL_LEVEL = 896
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           usb_rstn,
   input  logic [7:0]     wr_data,
   input  logic           wr_valid,
   output logic [7:0]     rd_data,
   output logic           rd_valid,
   input  logic           rd_ready,
   output logic [ASIZE:0] level,
   output logic           almost_full,
   output logic           overflow,
   output logic [15:0]    overflow_cnt,
   input  logic           clr_overflow
`ifdef RECV_LINE_DETECT_EN
   ,
   output logic           rd_eol,
   output logic           line_pending
`endif
);

   localparam int unsigned Depth = 2 ** ASIZE;
   localparam int unsigned PW    = ASIZE + 1;

   logic [7:0]     mem [Depth];
   logic [7:0]     ram_rdata_q;

   logic [ASIZE:0] wptr_q, wptr_d;
   logic [ASIZE:0] rptr_q, rptr_d;
   logic           infl_q, infl_d;
   logic [7:0]     skid0_q, skid0_d;
   logic [7:0]     skid1_q, skid1_d;
   logic [1:0]     skid_cnt_q, skid_cnt_d;
   logic [ASIZE:0] level_q, level_d;
   logic           afull_q, afull_d;
   logic           ovf_q, ovf_d;
   logic [15:0]    ovf_cnt_q, ovf_cnt_d;

   logic ram_empty, ram_full;
   logic wr_accept, drop, pop, rd_issue;

   assign ram_empty = (wptr_q == rptr_q);
   assign ram_full  = (wptr_q == {~rptr_q[ASIZE], rptr_q[ASIZE-1:0]});
   assign wr_accept = wr_valid & ~ram_full & usb_rstn;
   assign drop      = wr_valid & ram_full;
   assign pop       = rd_valid & rd_ready;

   // Issue a RAM read only if the skid can still take it once every byte
   // already committed to it (held + in flight - leaving now) has landed.
   assign rd_issue  = ~ram_empty & ((skid_cnt_q + 2'(infl_q) - 2'(pop)) < 2'd2);

   assign rd_valid     = (skid_cnt_q != 2'd0);
   assign rd_data      = skid0_q;
   assign level        = level_q;
   assign almost_full  = afull_q;
   assign overflow     = ovf_q;
   assign overflow_cnt = ovf_cnt_q;

   // RAM: write port and 1-cycle synchronous read port. A read never targets
   // the slot being written: reads need a non-empty RAM, writes a non-full one.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wptr_q[ASIZE-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_issue) begin
         ram_rdata_q <= mem[rptr_q[ASIZE-1:0]];
      end
   end

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      infl_d     = rd_issue;
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;
      skid_cnt_d = skid_cnt_q;

      if (wr_accept) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (rd_issue) begin
         rptr_d = rptr_q + PW'(1);
      end

      // Pop first, then land the in-flight byte behind whatever remains.
      if (pop) begin
         skid0_d    = skid1_q;
         skid_cnt_d = skid_cnt_q - 2'd1;
      end
      if (infl_q) begin
         if (skid_cnt_d == 2'd0) begin
            skid0_d = ram_rdata_q;
         end else begin
            skid1_d = ram_rdata_q;
         end
         skid_cnt_d = skid_cnt_d + 2'd1;
      end

      if (!usb_rstn) begin
         wptr_d     = '0;
         rptr_d     = '0;
         infl_d     = 1'b0;
         skid0_d    = '0;
         skid1_d    = '0;
         skid_cnt_d = '0;
      end

      level_d = (wptr_d - rptr_d) + PW'(skid_cnt_d) + PW'(infl_d);
      afull_d = (32'(level_d) >= AFULL_LEVEL);
   end

   // A drop in the same cycle as a clear leaves a fresh count of one.
   always_comb begin
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
      if (clr_overflow) begin
         ovf_d     = 1'b0;
         ovf_cnt_d = '0;
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (ovf_cnt_d != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_d + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         infl_q     <= 1'b0;
         skid0_q    <= '0;
         skid1_q    <= '0;
         skid_cnt_q <= '0;
         level_q    <= '0;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         infl_q     <= infl_d;
         skid0_q    <= skid0_d;
         skid1_q    <= skid1_d;
         skid_cnt_q <= skid_cnt_d;
         level_q    <= level_d;
         afull_q    <= afull_d;
         ovf_q      <= ovf_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

`ifdef RECV_LINE_DETECT_EN
   logic [ASIZE:0] eol_cnt_q, eol_cnt_d;
   logic           eol_in, eol_out;

   // Dropped bytes never reach wr_accept, so they are not counted.
   assign eol_in  = wr_accept & (wr_data == 8'h0A);
   assign eol_out = pop & (rd_data == 8'h0A);

   always_comb begin
      eol_cnt_d = eol_cnt_q;
      if (eol_in && !eol_out) begin
         eol_cnt_d = eol_cnt_q + PW'(1);
      end else if (!eol_in && eol_out) begin
         eol_cnt_d = eol_cnt_q - PW'(1);
      end
      if (!usb_rstn) begin
         eol_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         eol_cnt_q <= '0;
      end else begin
         eol_cnt_q <= eol_cnt_d;
      end
   end

   assign rd_eol       = rd_valid & (rd_data == 8'h0A);
   assign line_pending = (eol_cnt_q != '0);
`endif

endmodule

// File: tb/tb_usb_serial_recv_buffer.sv
// Self-checking bench for usb_serial_recv_buffer (ASIZE=4, 16-byte RAM).
module tb_usb_serial_recv_buffer;

   localparam int unsigned ASIZE = 4;
   localparam int unsigned AFULL = 14;

   logic           clk = 1'b0;
   logic           rst;
   logic           usb_rstn;
   logic [7:0]     wr_data;
   logic           wr_valid;
   logic [7:0]     rd_data;
   logic           rd_valid;
   logic           rd_ready;
   logic [ASIZE:0] level;
   logic           almost_full;
   logic           overflow;
   logic [15:0]    overflow_cnt;
   logic           clr_overflow;
`ifdef RECV_LINE_DETECT_EN
   logic           rd_eol;
   logic           line_pending;
`endif

   always #5 clk = ~clk;

   usb_serial_recv_buffer #(
      .ASIZE       (ASIZE),
      .AFULL_LEVEL (AFULL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .usb_rstn     (usb_rstn),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .level        (level),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .overflow_cnt (overflow_cnt),
      .clr_overflow (clr_overflow)
`ifdef RECV_LINE_DETECT_EN
      ,
      .rd_eol       (rd_eol),
      .line_pending (line_pending)
`endif
   );

   typedef struct {
      logic           wv;
      logic [7:0]     wd;
      logic           rr;
      logic [ASIZE:0] lvl;
      logic           v;
      logic [7:0]     d;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb_q[$];
   bit         sb_on = 1'b0;
   int         cyc = 0;
   int         xfer_cnt = 0;
   int         first_xfer = -1;
   int         last_xfer = -1;
   int         eol_pops = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample at the negedge (stall stability + scoreboard), then
   // return #1 after the posedge so the caller can check and drive.
   task automatic cycle();
      logic [7:0] exp_b;
      @(negedge clk);
      if (prev_stall) begin
         chk("stall_valid", 32'(rd_valid), 32'd1);
         chk("stall_data", 32'(rd_data), 32'(prev_data));
      end
      if (rd_valid && rd_ready) begin
         xfer_cnt++;
         if (first_xfer < 0) first_xfer = cyc;
         last_xfer = cyc;
         if (sb_on) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got %02h, expected no byte", rd_data);
            end else begin
               exp_b = sb_q.pop_front();
               chk("sb_data", 32'(rd_data), 32'(exp_b));
`ifdef RECV_LINE_DETECT_EN
               chk("sb_eol", 32'(rd_eol), 32'(exp_b == 8'h0A));
               if (rd_eol) eol_pops++;
`endif
            end
         end
      end
      prev_stall = rd_valid & ~rd_ready & ~rst & usb_rstn;
      prev_data  = rd_data;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      wr_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_valid = 1'b0;
      clr_overflow = 1'b0;
      usb_rstn = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      sb_q.delete();
      prev_stall = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[11];
      int   c0;
      int   sent;
      int   budget;

      rst = 1'b1;
      usb_rstn = 1'b1;
      wr_data = '0;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      clr_overflow = 1'b0;

      // ---------------- reset state ----------------
      cycle();
      cycle();
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_overflow_cnt", 32'(overflow_cnt), 32'd0);
`ifdef RECV_LINE_DETECT_EN
      chk("rst_rd_eol", 32'(rd_eol), 32'd0);
      chk("rst_line_pending", 32'(line_pending), 32'd0);
`endif
      rst = 1'b0;

      // ---------------- table-driven vectors ----------------
      // single byte latency, then a 3-byte stall/release sequence
      vecs[0]  = '{1'b1, 8'h41, 1'b1, 5'd1, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h41};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
      vecs[4]  = '{1'b1, 8'h10, 1'b0, 5'd1, 1'b0, 8'h00};
      vecs[5]  = '{1'b1, 8'h11, 1'b0, 5'd2, 1'b0, 8'h00};
      vecs[6]  = '{1'b1, 8'h12, 1'b0, 5'd3, 1'b1, 8'h10};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd3, 1'b1, 8'h10};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h11};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h12};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
      for (int i = 0; i < 11; i++) begin
         wr_valid = vecs[i].wv;
         wr_data  = vecs[i].wd;
         rd_ready = vecs[i].rr;
         cycle();
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
         chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].v));
         if (vecs[i].v) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].d));
      end
      chk("vec_overflow", 32'(overflow), 32'd0);

      // ---------------- burst of 64 with rd_ready high ----------------
      sb_on = 1'b1;
      rd_ready = 1'b1;
      xfer_cnt = 0;
      first_xfer = -1;
      c0 = cyc;
      for (int i = 0; i < 64; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(i);
         sb_q.push_back(8'(i));
         cycle();
      end
      idle(10);
      chk("burst_count", 32'(xfer_cnt), 32'd64);
      chk("burst_latency", 32'(first_xfer - c0), 32'd3);
      chk("burst_no_gaps", 32'(last_xfer - first_xfer), 32'd63);
      chk("burst_sb_empty", 32'(sb_q.size()), 32'd0);

      // ---------------- fill with rd_ready low ----------------
      do_reset();
      rd_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(i);
         if (i < 18) sb_q.push_back(8'(i));
         cycle();
      end
      idle(3);
      chk("fill_level", 32'(level), 32'd18);
      chk("fill_overflow", 32'(overflow), 32'd1);
      chk("fill_overflow_cnt", 32'(overflow_cnt), 32'd2);
      chk("fill_almost_full", 32'(almost_full), 32'd1);
      chk("fill_head", 32'(rd_data), 32'd0);
      rd_ready = 1'b1;
      idle(30);
      chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("drain_level", 32'(level), 32'd0);
      chk("drain_almost_full", 32'(almost_full), 32'd0);

      // ---------------- flush via usb_rstn ----------------
      sb_on = 1'b0;
      rd_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'hA0 + i);
         cycle();
      end
      idle(3);
      chk("pre_flush_level", 32'(level), 32'd10);
      usb_rstn = 1'b0;
      cycle();
      usb_rstn = 1'b1;
      chk("flush_rd_valid", 32'(rd_valid), 32'd0);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_overflow_kept", 32'(overflow), 32'd1);
      chk("flush_overflow_cnt_kept", 32'(overflow_cnt), 32'd2);
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("flush_no_stale", 32'(rd_valid), 32'd0);
      end

      // ---------------- clr_overflow together with a drop ----------------
      rd_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'h50 + i);
         cycle();
      end
      idle(3);
      chk("refill_level", 32'(level), 32'd18);
      chk("refill_no_drop", 32'(overflow_cnt), 32'd2);
      wr_valid = 1'b1;
      clr_overflow = 1'b1;
      cycle();
      wr_valid = 1'b0;
      clr_overflow = 1'b0;
      chk("clr_drop_overflow", 32'(overflow), 32'd1);
      chk("clr_drop_cnt", 32'(overflow_cnt), 32'd1);
      clr_overflow = 1'b1;
      cycle();
      clr_overflow = 1'b0;
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_cnt", 32'(overflow_cnt), 32'd0);

      // ---------------- rst mid-stream ----------------
      rd_ready = 1'b1;
      idle(2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
      chk("midrst_level", 32'(level), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("midrst_no_stale", 32'(rd_valid), 32'd0);
      end

      // ---------------- random backpressure, 1000 bytes ----------------
      do_reset();
      sb_on = 1'b1;
      xfer_cnt = 0;
      sent = 0;
      budget = 0;
      while ((sent < 1000 || sb_q.size() != 0) && budget < 20000) begin
         // keep outstanding bytes within RAM depth so nothing is dropped
         if (sent < 1000 && sb_q.size() < 16 && $urandom_range(0, 3) != 0) begin
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
            sb_q.push_back(wr_data);
            sent++;
         end else begin
            wr_valid = 1'b0;
         end
         rd_ready = ($urandom_range(0, 2) != 0);
         cycle();
         budget++;
      end
      wr_valid = 1'b0;
      chk("bp_sent", 32'(sent), 32'd1000);
      chk("bp_received", 32'(xfer_cnt), 32'd1000);
      chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("bp_overflow", 32'(overflow), 32'd0);

`ifdef RECV_LINE_DETECT_EN
      // ---------------- line detection ----------------
      do_reset();
      sb_on = 1'b1;
      rd_ready = 1'b0;
      eol_pops = 0;
      begin
         logic [7:0] line_bytes [6];
         line_bytes = '{8'h61, 8'h62, 8'h0A, 8'h63, 8'h64, 8'h0A};
         for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = line_bytes[i];
            sb_q.push_back(line_bytes[i]);
            cycle();
         end
      end
      idle(3);
      chk("line_pending_set", 32'(line_pending), 32'd1);
      rd_ready = 1'b1;
      idle(10);
      chk("line_eol_pops", 32'(eol_pops), 32'd2);
      chk("line_pending_clear", 32'(line_pending), 32'd0);
      chk("line_sb_empty", 32'(sb_q.size()), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
